// File: rtl/fetch_buf.sv
// Fetch buffer: small circular FIFO of {pc, inst} pairs between instruction
// memory and the realigner, with flush (redirect) and downstream stall.
module fetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       imem_valid_i,
   input  logic [31:0]                imem_pc_i,
   input  logic [31:0]                imem_inst_i,
   output logic                       imem_ready_o,
   input  logic                       flush_i,
   input  logic                       stall_i,
   output logic                       valid_o,
   output logic [31:0]                pc_o,
   output logic [31:0]                inst_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_CNT = CW'(0);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [AW-1:0] ONE_PTR  = AW'(1);

   logic [31:0]   mem_pc_r   [DEPTH];
   logic [31:0]   mem_inst_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   last_pc_r;
   logic          push_s;
   logic          pop_s;

   // Ready and valid depend only on the registered occupancy.
   assign imem_ready_o = (count_r != FULL_CNT);
   assign valid_o      = (count_r != ZERO_CNT);
   assign count_o      = count_r;
   assign push_s       = imem_valid_i && imem_ready_o && !flush_i;
   assign pop_s        = valid_o && !stall_i && !flush_i;

   // Head presentation; an empty buffer shows a NOP at the last consumed PC.
   always_comb begin
      pc_o   = last_pc_r;
      inst_o = NOP_INST;
      if (valid_o) begin
         pc_o   = mem_pc_r[rptr_r];
         inst_o = mem_inst_r[rptr_r];
      end else begin
         pc_o   = last_pc_r;
         inst_o = NOP_INST;
      end
   end

   // Storage array write; contents are left as-is on reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_pc_r[wptr_r]   <= imem_pc_i;
         mem_inst_r[wptr_r] <= imem_inst_i;
      end
   end

   // Pointers, occupancy and last-popped PC; reset beats flush beats push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r    <= '0;
         rptr_r    <= '0;
         count_r   <= '0;
         last_pc_r <= 32'h0000_0000;
      end else if (flush_i) begin
         rptr_r    <= wptr_r;
         count_r   <= '0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rptr_r    <= rptr_r + ONE_PTR;
            last_pc_r <= mem_pc_r[rptr_r];
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_CNT;
            2'b01:   count_r <= count_r - ONE_CNT;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_buf.sv
// Randomised bench for fetch_buf: a queue-based reference model posts the
// expected outputs for every cycle, and a separate monitor compares them.
module tb_fetch_buf;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_valid_i;
   logic [31:0] imem_pc_i;
   logic [31:0] imem_inst_i;
   logic        imem_ready_o;
   logic        flush_i;
   logic        stall_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic [2:0]  count_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   typedef struct {
      logic        valid;
      logic        ready;
      logic [2:0]  count;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   entry_t      ref_q[$];
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] last_pc = 32'h0;
   logic [31:0] rpc;
   int          checks = 0;
   int          failures = 0;

   fetch_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_valid_i (imem_valid_i),
      .imem_pc_i    (imem_pc_i),
      .imem_inst_i  (imem_inst_i),
      .imem_ready_o (imem_ready_o),
      .flush_i      (flush_i),
      .stall_i      (stall_i),
      .valid_o      (valid_o),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .count_o      (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // One cycle: drive inputs, post the expected outputs, then advance the model.
   task automatic cycle(input logic rst, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic fl, input logic st);
      exp_t   e;
      entry_t n;
      logic   acc;
      reset        = rst;
      imem_valid_i = v;
      imem_pc_i    = pc;
      imem_inst_i  = inst;
      flush_i      = fl;
      stall_i      = st;
      e.valid = (ref_q.size() != 0);
      e.ready = (ref_q.size() != DEPTH);
      e.count = 3'(ref_q.size());
      e.pc    = e.valid ? ref_q[0].pc   : last_pc;
      e.inst  = e.valid ? ref_q[0].inst : NOP;
      exp_q.push_back(e);
      acc = v && (ref_q.size() < DEPTH);
      @(posedge clk);
      if (rst) begin
         ref_q.delete();
         last_pc = 32'h0;
      end else if (fl) begin
         ref_q.delete();
      end else begin
         if (ref_q.size() != 0 && !st) begin
            last_pc = ref_q[0].pc;
            void'(ref_q.pop_front());
         end
         if (acc) begin
            n.pc   = pc;
            n.inst = inst;
            ref_q.push_back(n);
         end
      end
      #1;
   endtask

   // Monitor: compares every posted expectation against the live outputs.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("valid_o", {31'h0, valid_o}, {31'h0, mon_e.valid});
         check("imem_ready_o", {31'h0, imem_ready_o}, {31'h0, mon_e.ready});
         check("count_o", {29'h0, count_o}, {29'h0, mon_e.count});
         check("pc_o", pc_o, mon_e.pc);
         check("inst_o", inst_o, mon_e.inst);
         check("count_bound", {31'h0, (count_o <= 3'(DEPTH))}, 32'h1);
      end
   end

   initial begin
      reset = 1'b1; imem_valid_i = 1'b0; imem_pc_i = 32'h0; imem_inst_i = 32'h0;
      flush_i = 1'b0; stall_i = 1'b0;
      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      // First word visible the cycle after it is pushed.
      cycle(1'b0, 1'b1, 32'h1000, 32'h00A0_0093, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      // Fill under stall, refused fifth word, then drain in order.
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b1, 32'h2000 + 32'(4 * i), $urandom, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      // Simultaneous push and pop at count 2.
      cycle(1'b0, 1'b1, 32'h2100, $urandom, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 32'h2104, $urandom, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 32'h2108, $urandom, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      // Flush at count 3 with a same-cycle push that must be dropped.
      cycle(1'b0, 1'b1, 32'h210C, $urandom, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 32'h3000, 32'h1234_5678, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      // Random traffic across pointer wrap, with occasional flushes.
      rpc = 32'h4000;
      for (int i = 0; i < 60; i++) begin
         logic v;
         logic st;
         logic fl;
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 15) == 0);
         cycle(1'b0, v, rpc, $urandom, fl, st);
         if (v) rpc = rpc + 32'h4;
      end
      // Reset mid-stream with count 3.
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, 32'h5000 + 32'(4 * i), $urandom, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 32'h5100, $urandom, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
